// File: rtl/vproc_fetch_seq_pkg.sv
// Shared types and helpers for the vector operand-fetch sequencer.
// Register groups are described by a 5-bit base and a register count (1..8).
package vproc_fetch_seq_pkg;

    typedef enum logic [1:0] {
        EMUL_1 = 2'd0,
        EMUL_2 = 2'd1,
        EMUL_4 = 2'd2,
        EMUL_8 = 2'd3
    } cfg_emul;

    typedef struct packed {
        logic       vreg;
        logic [4:0] vreg_addr;
        logic       fetch;
        logic       shift;
        logic       narrow;
        logic       clear_hazard;
    } fetch_info;

    typedef struct packed {
        logic vreg;
        logic shift;
    } store_info;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state;

    // Decode guarantees group alignment, so OR-ing the step index is an add.
    function automatic logic [4:0] fetch_update_addr(input logic [4:0] base, input logic [2:0] idx);
        return base | {2'b00, idx};
    endfunction

    function automatic logic [3:0] emul_regs(input cfg_emul emul, input logic narrow);
        logic [3:0] n;
        n = 4'd1 << emul;
        if (narrow && emul != EMUL_1) begin
            n = n >> 1;
        end
        return n;
    endfunction

    function automatic logic [31:0] group_mask(input logic [4:0] base, input logic [3:0] count);
        logic [31:0] m;
        logic [4:0]  idx;
        m = '0;
        for (int j = 0; j < 8; j++) begin
            if (4'(j) < count) begin
                idx    = base + 5'(j);
                m[idx] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/vproc_fetch_seq_op.sv
// Per-operand step decode: maps the step index and job fields to a fetch record
// and the hazard-clear mask this operand contributes on its final read.
module vproc_fetch_seq_op
    import vproc_fetch_seq_pkg::*;
(
    input  logic [2:0]  idx,
    input  cfg_emul     emul,
    input  logic        vreg,
    input  logic [4:0]  base,
    input  logic        narrow,
    output fetch_info   info,
    output logic [31:0] clear_mask
);

    logic [2:0] last_idx;
    logic [2:0] read_idx;

    always_comb begin
        last_idx = 3'((4'd1 << emul) - 4'd1);
        // A narrow group's last read is issued one step before the job ends.
        if (narrow) begin
            last_idx = (emul == EMUL_1) ? 3'd0 : last_idx - 3'd1;
        end
        read_idx = narrow ? {1'b0, idx[2:1]} : idx;

        info.vreg         = vreg;
        info.vreg_addr    = fetch_update_addr(base, read_idx);
        info.fetch        = narrow ? (vreg & ~idx[0]) : vreg;
        info.shift        = narrow ? (idx[0] | (emul == EMUL_1)) : 1'b1;
        info.narrow       = narrow;
        info.clear_hazard = (idx == last_idx);

        clear_mask = (info.clear_hazard & vreg) ? group_mask(base, emul_regs(emul, narrow)) : '0;
    end

endmodule

// File: rtl/vproc_fetch_seq.sv
// Operand-fetch sequencer: accepts one job, walks its register group one step per
// handshake and pulses the read-hazard clear mask after each operand's last read.
module vproc_fetch_seq
    import vproc_fetch_seq_pkg::*;
#(
    parameter int unsigned OP_CNT     = 2,
    parameter bit          CLEAR_LATE = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    sync_rst_ni,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  cfg_emul                 job_emul_i,
    input  logic [OP_CNT-1:0]       job_vs_vreg_i,
    input  logic [OP_CNT*5-1:0]     job_vs_addr_i,
    input  logic [OP_CNT-1:0]       job_vs_narrow_i,
    input  logic                    job_vd_vreg_i,
    input  logic [4:0]              job_vd_addr_i,
    output logic                    step_valid_o,
    input  logic                    step_ready_i,
    output fetch_info [OP_CNT-1:0]  step_fetch_o,
    output store_info               step_store_o,
    output logic [4:0]              step_vd_addr_o,
    output logic                    step_first_o,
    output logic                    step_last_o,
    output logic [31:0]             clear_rd_hazards_o,
    output logic                    busy_o
);

    // Handshakes: a transfer happens on a rising clk_i edge where valid & ready.
    // Job: job_valid_i/job_ready_o. Step: step_valid_o/step_ready_i; step outputs
    // hold stable while step_valid_o & ~step_ready_i.
    seq_state            state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    cfg_emul             emul_q;
    logic [OP_CNT-1:0]   vs_vreg_q, vs_narrow_q;
    logic [OP_CNT*5-1:0] vs_addr_q;
    logic                vd_vreg_q;
    logic [4:0]          vd_addr_q;
    logic                job_hs, step_hs, last_step;
    logic [OP_CNT-1:0][31:0] op_mask;
    logic [31:0]         step_mask, clr_q;

    assign last_step = (idx_q == 3'((4'd1 << emul_q) - 4'd1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        step_valid_o = (state_q == SEQ_RUN);
        job_ready_o  = (state_q == SEQ_IDLE) | (step_valid_o & step_ready_i & last_step);
        job_hs       = job_valid_i & job_ready_o;
        step_hs      = step_valid_o & step_ready_i;
        if (job_hs) begin
            state_d = SEQ_RUN;
            idx_d   = '0;
        end else if (step_hs && last_step) begin
            state_d = SEQ_IDLE;
        end else if (step_hs) begin
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            state_q     <= SEQ_IDLE;
            idx_q       <= '0;
            emul_q      <= EMUL_1;
            vs_vreg_q   <= '0;
            vs_addr_q   <= '0;
            vs_narrow_q <= '0;
            vd_vreg_q   <= 1'b0;
            vd_addr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (job_hs) begin
                emul_q      <= job_emul_i;
                vs_vreg_q   <= job_vs_vreg_i;
                vs_addr_q   <= job_vs_addr_i;
                vs_narrow_q <= job_vs_narrow_i;
                vd_vreg_q   <= job_vd_vreg_i;
                vd_addr_q   <= job_vd_addr_i;
            end
        end
    end

    for (genvar k = 0; k < OP_CNT; k++) begin : g_op
        vproc_fetch_seq_op u_op (
            .idx        (idx_q),
            .emul       (emul_q),
            .vreg       (vs_vreg_q[k]),
            .base       (vs_addr_q[k*5 +: 5]),
            .narrow     (vs_narrow_q[k]),
            .info       (step_fetch_o[k]),
            .clear_mask (op_mask[k])
        );
    end

    always_comb begin
        step_mask = '0;
        for (int k = 0; k < OP_CNT; k++) begin
            step_mask = step_mask | op_mask[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            clr_q <= '0;
        end else begin
            clr_q <= step_hs ? step_mask : '0;
        end
    end

    if (CLEAR_LATE) begin : g_late
        logic [31:0] clr_late_q;
        always_ff @(posedge clk_i) begin
            if (!sync_rst_ni) begin
                clr_late_q <= '0;
            end else begin
                clr_late_q <= clr_q;
            end
        end
        assign clear_rd_hazards_o = clr_late_q;
    end else begin : g_early
        assign clear_rd_hazards_o = clr_q;
    end

    assign step_store_o   = '{vreg: vd_vreg_q, shift: 1'b1};
    assign step_vd_addr_o = fetch_update_addr(vd_addr_q, idx_q);
    assign step_first_o   = (idx_q == 3'd0);
    assign step_last_o    = last_step;
    assign busy_o         = (state_q == SEQ_RUN);

endmodule

// File: tb/tb_vproc_fetch_seq.sv
// Bench for vproc_fetch_seq: directed and random jobs checked cycle by cycle
// against a job-level model of the step sequence and hazard-clear pulses.
module tb_vproc_fetch_seq;
    import vproc_fetch_seq_pkg::*;

    localparam int OP_CNT     = 2;
    localparam bit CLEAR_LATE = 1'b0;

    logic                   clk_i = 1'b0;
    logic                   sync_rst_ni;
    logic                   job_valid_i;
    logic                   job_ready_o;
    cfg_emul                job_emul_i;
    logic [OP_CNT-1:0]      job_vs_vreg_i;
    logic [OP_CNT*5-1:0]    job_vs_addr_i;
    logic [OP_CNT-1:0]      job_vs_narrow_i;
    logic                   job_vd_vreg_i;
    logic [4:0]             job_vd_addr_i;
    logic                   step_valid_o;
    logic                   step_ready_i;
    fetch_info [OP_CNT-1:0] step_fetch_o;
    store_info              step_store_o;
    logic [4:0]             step_vd_addr_o;
    logic                   step_first_o;
    logic                   step_last_o;
    logic [31:0]            clear_rd_hazards_o;
    logic                   busy_o;

    vproc_fetch_seq #(.OP_CNT(OP_CNT), .CLEAR_LATE(CLEAR_LATE)) dut (
        .clk_i              (clk_i),
        .sync_rst_ni        (sync_rst_ni),
        .job_valid_i        (job_valid_i),
        .job_ready_o        (job_ready_o),
        .job_emul_i         (job_emul_i),
        .job_vs_vreg_i      (job_vs_vreg_i),
        .job_vs_addr_i      (job_vs_addr_i),
        .job_vs_narrow_i    (job_vs_narrow_i),
        .job_vd_vreg_i      (job_vd_vreg_i),
        .job_vd_addr_i      (job_vd_addr_i),
        .step_valid_o       (step_valid_o),
        .step_ready_i       (step_ready_i),
        .step_fetch_o       (step_fetch_o),
        .step_store_o       (step_store_o),
        .step_vd_addr_o     (step_vd_addr_o),
        .step_first_o       (step_first_o),
        .step_last_o        (step_last_o),
        .clear_rd_hazards_o (clear_rd_hazards_o),
        .busy_o             (busy_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0] emul;
        logic [1:0] vs_vreg;
        logic [9:0] vs_addr;
        logic [1:0] vs_narrow;
        logic       vd_vreg;
        logic [4:0] vd_addr;
    } job_t;

    job_t        jq[$];
    logic [31:0] exp_q[$];
    job_t        cur;
    int          m_i;
    bit          m_active;
    int          total = 0;
    int          bad = 0;
    int          cycles = 0;
    int          ready_mode = 0;
    int          stall_left = 0;
    int          rst_at = -1;
    logic [31:0] acc_clr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: step i of a job, straight from the group-walk rules.
    function automatic fetch_info exp_fetch(input job_t j, input int i, input int k);
        fetch_info f;
        int n;
        logic [4:0] base;
        n = 1 << j.emul;
        base = j.vs_addr[k*5 +: 5];
        f.vreg   = j.vs_vreg[k];
        f.narrow = j.vs_narrow[k];
        if (j.vs_narrow[k]) begin
            f.vreg_addr    = base | 5'(i / 2);
            f.fetch        = j.vs_vreg[k] && (i % 2 == 0);
            f.shift        = (i % 2 == 1) || (n == 1);
            f.clear_hazard = (i == ((n >= 2) ? n - 2 : 0));
        end else begin
            f.vreg_addr    = base | 5'(i);
            f.fetch        = j.vs_vreg[k];
            f.shift        = 1'b1;
            f.clear_hazard = (i == n - 1);
        end
        return f;
    endfunction

    function automatic logic [31:0] exp_mask(input job_t j, input int i);
        logic [31:0] m;
        fetch_info f;
        int n, r, base;
        m = '0;
        n = 1 << j.emul;
        for (int k = 0; k < OP_CNT; k++) begin
            f = exp_fetch(j, i, k);
            if (f.clear_hazard && f.vreg) begin
                r = j.vs_narrow[k] ? ((n > 1) ? n / 2 : 1) : n;
                base = int'(j.vs_addr[k*5 +: 5]);
                for (int b = 0; b < r; b++) m[(base + b) % 32] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic job_t mk_job(input int emul, input logic [1:0] vreg, input int a0, input int a1,
                                    input logic [1:0] narrow, input logic vdv, input int vd);
        job_t j;
        j.emul      = 2'(emul);
        j.vs_vreg   = vreg;
        j.vs_addr   = {5'(a1), 5'(a0)};
        j.vs_narrow = narrow;
        j.vd_vreg   = vdv;
        j.vd_addr   = 5'(vd);
        return j;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_i = 0;
        jq.delete();
        exp_q.delete();
        repeat (int'(CLEAR_LATE)) exp_q.push_back('0);
    endtask

    // driver: one clock cycle of stimulus, checks, and model update
    task automatic tick();
        bit rdy, rst, m_ready, hs_step, hs_job, last;
        int n;
        logic [31:0] pulse, expv;
        job_t jh;
        n = 1 << cur.emul;
        last = m_active && (m_i == n - 1);
        job_valid_i = (jq.size() > 0);
        jh = job_valid_i ? jq[0] : job_t'($urandom);
        job_emul_i      = cfg_emul'(jh.emul);
        job_vs_vreg_i   = jh.vs_vreg;
        job_vs_addr_i   = jh.vs_addr;
        job_vs_narrow_i = jh.vs_narrow;
        job_vd_vreg_i   = jh.vd_vreg;
        job_vd_addr_i   = jh.vd_addr;
        case (ready_mode)
            1: rdy = ($urandom_range(0, 3) != 0);
            2: begin
                rdy = 1'b1;
                if (m_active && m_i == 1 && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end
            end
            default: rdy = 1'b1;
        endcase
        step_ready_i = rdy;
        rst = !(rst_at >= 0 && m_active && cur.emul == 2'd3 && m_i == rst_at);
        if (!rst) rst_at = -1;
        sync_rst_ni = rst;
        #1;
        m_ready = !m_active || (rdy && last);
        chk("step_valid", 32'(step_valid_o), 32'(m_active));
        chk("job_ready", 32'(job_ready_o), 32'(m_ready));
        chk("busy", 32'(busy_o), 32'(m_active));
        if (m_active) begin
            for (int k = 0; k < OP_CNT; k++)
                chk($sformatf("fetch%0d_i%0d", k, m_i), 32'(step_fetch_o[k]), 32'(exp_fetch(cur, m_i, k)));
            chk("store", 32'(step_store_o), {30'd0, cur.vd_vreg, 1'b1});
            chk("vd_addr", 32'(step_vd_addr_o), 32'(cur.vd_addr | 5'(m_i)));
            chk("first", 32'(step_first_o), 32'(m_i == 0));
            chk("last", 32'(step_last_o), 32'(last));
        end
        if (!rst) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            hs_step = m_active && rdy;
            hs_job  = job_valid_i && m_ready;
            pulse   = hs_step ? exp_mask(cur, m_i) : '0;
            exp_q.push_back(pulse);
            if (hs_job) begin
                cur = jq.pop_front();
                m_i = 0;
                m_active = 1'b1;
            end else if (hs_step) begin
                if (last) m_active = 1'b0;
                else m_i++;
            end
        end
        @(posedge clk_i);
        #1;
        cycles++;
        expv = exp_q.pop_front();
        chk("clear_mask", clear_rd_hazards_o, expv);
        acc_clr = acc_clr | clear_rd_hazards_o;
    endtask

    task automatic run_jobs();
        int start;
        start = cycles;
        while ((jq.size() > 0 || m_active) && (cycles - start) < 2000) tick();
        chk("drain_timeout", 32'(jq.size() > 0 || m_active), 32'd0);
        repeat (2) tick();
    endtask

    initial begin
        sync_rst_ni     = 1'b0;
        job_valid_i     = 1'b0;
        job_emul_i      = EMUL_1;
        job_vs_vreg_i   = '0;
        job_vs_addr_i   = '0;
        job_vs_narrow_i = '0;
        job_vd_vreg_i   = 1'b0;
        job_vd_addr_i   = '0;
        step_ready_i    = 1'b1;
        cur             = '0;
        acc_clr         = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_step_valid", 32'(step_valid_o), 32'd0);
        chk("rst_job_ready", 32'(job_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_clear", clear_rd_hazards_o, 32'd0);
        model_reset();

        // EMUL_1, vs0=v4 wide, vs1=v8 narrow
        acc_clr = '0;
        jq.push_back(mk_job(0, 2'b11, 4, 8, 2'b10, 1'b1, 12));
        run_jobs();
        chk("emul1_mask", acc_clr, 32'h0000_0110);

        // EMUL_4, vs0=v8 wide, vs1=v4 narrow
        acc_clr = '0;
        jq.push_back(mk_job(2, 2'b11, 8, 4, 2'b10, 1'b1, 16));
        run_jobs();
        chk("emul4_mask", acc_clr, 32'h0000_0F30);

        // EMUL_2 with a 3-cycle stall at i=1
        acc_clr = '0;
        ready_mode = 2;
        stall_left = 3;
        jq.push_back(mk_job(1, 2'b11, 2, 6, 2'b00, 1'b0, 20));
        run_jobs();
        chk("stall_mask", acc_clr, 32'h0000_00CC);
        ready_mode = 0;

        // back-to-back EMUL_2 jobs
        jq.push_back(mk_job(1, 2'b11, 10, 14, 2'b01, 1'b1, 2));
        jq.push_back(mk_job(1, 2'b11, 18, 22, 2'b10, 1'b0, 4));
        run_jobs();

        // reset during an EMUL_8 job at i=5
        acc_clr = '0;
        rst_at = 5;
        jq.push_back(mk_job(3, 2'b11, 8, 16, 2'b10, 1'b1, 24));
        run_jobs();
        chk("reset_no_clear", acc_clr, 32'd0);
        chk("reset_idle_ready", 32'(job_ready_o), 32'd1);

        // scalar vs1, EMUL_8
        acc_clr = '0;
        jq.push_back(mk_job(3, 2'b01, 0, 16, 2'b00, 1'b1, 8));
        run_jobs();
        chk("scalar_mask", acc_clr, 32'h0000_00FF);

        // random jobs, random downstream ready
        ready_mode = 1;
        for (int b = 0; b < 10; b++) begin
            for (int q = 0; q < 3; q++) jq.push_back(job_t'($urandom));
            run_jobs();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
